// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int CNT_W_DEF  = 2;

  // Address width needed to index nreg registers (nreg is a power of two >= 2).
  function automatic int addr_width(input int nreg);
    return (nreg < 2) ? 1 : $clog2(nreg);
  endfunction

  // Largest value a pending counter of width w can hold.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int CNT_MAX_DEF = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file scoreboard.
//
// Handshake: there is no valid/ready pair. Reads are purely combinational.
// wr_en commits wr_data on the rising edge. iss_en is an issue request that is
// accepted on the rising edge only when iss_full is low in that same cycle;
// a refused issue must be held (retried) by the decode stage.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);
  localparam int AW = addr_width(NREG);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   iss_full;
  logic                   flush;

  // Pipeline side (decode + writeback).
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_full
  );

  // Register file side.
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_full
  );

endinterface

// File: rtl/regfile_scoreboard_pending_counter.sv
// Per-register count of in-flight writes: saturates at max, holds at zero.
module pending_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up, down;

  // Next count: clear wins; a retire only counts against a non-zero count,
  // and a matching issue+retire pair cancels out.
  always_comb begin
    up    = inc_i && (cnt_q != MAX);
    down  = dec_i && (cnt_q != '0);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (up && !down) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (down && !up) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, write-to-read bypass and a
// per-register pending-write scoreboard for RAW hazard detection.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  regfile_scoreboard_if.slave bus
);

  localparam int               AW      = addr_width(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [XLEN-1:0]  mem_q [NREG];
  logic [CNT_W-1:0] cnt   [NREG];

  logic wr_hit;
  logic iss_req;
  logic iss_at_max;
  logic iss_ok;

  assign wr_hit     = bus.wr_en && (bus.wr_addr != '0);
  assign iss_req    = bus.iss_en && (bus.iss_addr != '0);
  assign iss_at_max = (cnt[bus.iss_addr] == CNT_MAX);
  assign iss_ok     = iss_req && !iss_at_max;
  assign bus.iss_full = iss_req && iss_at_max;

  // Register storage; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else if (wr_hit) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // x0 has no pending writes by construction.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc_i (iss_ok && (bus.iss_addr == AW'(r))),
      .dec_i (wr_hit && (bus.wr_addr == AW'(r))),
      .clr_i (bus.flush),
      .cnt_o (cnt[r])
    );
  end

  // Read ports: zero for x0 and while reset is held, else bypass, else storage.
  // Busy masks out the one pending write that is retiring right now.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = bus.rd_addr[i*AW +: AW];
    assign hit = bus.wr_en && (bus.wr_addr == a);
    assign bus.rd_data[i*XLEN +: XLEN] =
      (!reset || (a == '0)) ? '0 : (hit ? bus.wr_data : mem_q[a]);
    assign bus.rd_busy[i] = cnt[a] > (hit ? CNT_W'(1) : CNT_W'(0));
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard (expected-value queue).
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int NUM_RD = 2;
  localparam int CNT_W  = 2;
  localparam int AW     = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [XLEN-1:0] model_mem [NREG];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check_val(tag, got, e);
  endtask

  // Expected tuple: rd_data port0, rd_data port1, rd_busy, iss_full.
  task automatic expect4(input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] busy, input logic [31:0] full);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(busy);
    exp_q.push_back(full);
  endtask

  task automatic observe4(input string tag);
    #1;
    pop_check({tag, "/rd0"},  bus.rd_data[0 +: XLEN]);
    pop_check({tag, "/rd1"},  bus.rd_data[XLEN +: XLEN]);
    pop_check({tag, "/busy"}, {30'd0, bus.rd_busy});
    pop_check({tag, "/full"}, {31'd0, bus.iss_full});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    for (int r = 0; r < NREG; r++) model_mem[r] = '0;
  endtask

  task automatic idle();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic set_iss(input logic en, input logic [AW-1:0] a);
    bus.iss_en   = en;
    bus.iss_addr = a;
  endtask

  // One rising edge; returns at the following falling edge.
  task automatic step();
    if (reset && bus.wr_en && bus.wr_addr != '0) model_mem[bus.wr_addr] = bus.wr_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic            r_wen;
    logic [AW-1:0]   r_wa, r_a0, r_a1;
    logic [XLEN-1:0] r_wd, e0, e1;

    idle();
    clear_model();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    set_rd(0, 5); set_rd(1, 0);
    expect4(0, 0, 0, 0); observe4("reset_hold");
    @(negedge clk);
    reset = 1'b1;

    // Write x5, then asynchronous reset mid-cycle
    set_wr(1'b1, 5, 32'hDEAD_BEEF);
    expect4(32'hDEAD_BEEF, 0, 0, 0); observe4("wr5_bypass");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'hDEAD_BEEF, 0, 0, 0); observe4("wr5_stored");
    reset = 1'b0;
    clear_model();
    expect4(0, 0, 0, 0); observe4("async_reset");
    step();
    reset = 1'b1;
    expect4(0, 0, 0, 0); observe4("post_reset");

    // Writes to x0 are dropped, no bypass
    set_rd(0, 0); set_rd(1, 0);
    set_wr(1'b1, 0, 32'h1234);
    expect4(0, 0, 0, 0); observe4("x0_same_cycle");
    step();
    set_wr(1'b0, 0, 0);
    expect4(0, 0, 0, 0); observe4("x0_after");

    // Bypass
    set_wr(1'b1, 7, 32'h11);
    step();
    set_wr(1'b0, 0, 0);
    set_rd(1, 7);
    expect4(0, 32'h11, 0, 0); observe4("x7_stored");
    set_rd(0, 7);
    set_wr(1'b1, 7, 32'h22);
    expect4(32'h22, 32'h22, 0, 0); observe4("x7_bypass");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'h22, 32'h22, 0, 0); observe4("x7_after");

    // Scoreboard on x3
    set_rd(0, 3); set_rd(1, 3);
    set_iss(1'b1, 3);
    expect4(0, 0, 0, 0); observe4("x3_iss1");
    step();
    expect4(0, 0, 3, 0); observe4("x3_iss2");
    step();
    set_iss(1'b0, 0);
    expect4(0, 0, 3, 0); observe4("x3_cnt2");
    set_wr(1'b1, 3, 32'hA);
    expect4(32'hA, 32'hA, 3, 0); observe4("x3_retire1");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'hA, 32'hA, 3, 0); observe4("x3_cnt1");
    set_wr(1'b1, 3, 32'hB);
    expect4(32'hB, 32'hB, 0, 0); observe4("x3_final_retire");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'hB, 32'hB, 0, 0); observe4("x3_cnt0");

    // Saturation on x9
    set_rd(0, 9); set_rd(1, 3);
    set_iss(1'b1, 9);
    repeat (3) step();
    expect4(0, 32'hB, 1, 1); observe4("x9_full");
    step();
    expect4(0, 32'hB, 1, 1); observe4("x9_still_full");
    set_wr(1'b1, 9, 32'h99);
    expect4(32'h99, 32'hB, 1, 1); observe4("x9_refused_retire");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'h99, 32'hB, 1, 0); observe4("x9_cnt2");
    set_iss(1'b0, 0);
    set_wr(1'b1, 9, 32'h9A);
    step();
    set_wr(1'b1, 9, 32'h9B);
    expect4(32'h9B, 32'hB, 0, 0); observe4("x9_last_retire");
    step();
    set_wr(1'b0, 0, 0);
    expect4(32'h9B, 32'hB, 0, 0); observe4("x9_drained");

    // Simultaneous issue/retire, then flush
    set_rd(0, 4); set_rd(1, 6);
    set_iss(1'b1, 4);
    step();
    set_iss(1'b1, 6);
    step();
    set_iss(1'b1, 4);
    set_wr(1'b1, 4, 32'h44);
    expect4(32'h44, 0, 2, 0); observe4("x4_iss_and_retire");
    step();
    set_iss(1'b0, 0);
    set_wr(1'b0, 0, 0);
    expect4(32'h44, 0, 3, 0); observe4("x4_cnt_held");
    set_wr(1'b1, 4, 32'h45);
    expect4(32'h45, 0, 2, 0); observe4("x4_cnt_is_1");
    set_wr(1'b1, 12, 32'h5A5A);
    bus.flush = 1'b1;
    set_iss(1'b1, 6);
    step();
    bus.flush = 1'b0;
    set_iss(1'b0, 0);
    set_wr(1'b0, 0, 0);
    expect4(32'h44, 0, 0, 0); observe4("flush_cleared");
    set_rd(1, 12);
    expect4(32'h44, 32'h5A5A, 0, 0); observe4("flush_write_kept");
    step();

    // Random writes/reads; counters are all zero, so retires must not underflow
    for (int n = 0; n < 40; n++) begin
      r_wen = 1'($urandom_range(0, 1));
      r_wa  = AW'($urandom_range(0, NREG - 1));
      r_wd  = $urandom;
      r_a0  = AW'($urandom_range(0, NREG - 1));
      r_a1  = (n % 4 == 0) ? r_wa : AW'($urandom_range(0, NREG - 1));
      set_wr(r_wen, r_wa, r_wd);
      set_rd(0, r_a0); set_rd(1, r_a1);
      e0 = (r_a0 == 0) ? '0 : ((r_wen && r_wa == r_a0) ? r_wd : model_mem[r_a0]);
      e1 = (r_a1 == 0) ? '0 : ((r_wen && r_wa == r_a1) ? r_wd : model_mem[r_a1]);
      expect4(e0, e1, 0, 0); observe4("rand");
      step();
    end
    idle();

    check_val("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
